// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//
// Purpose:
//   Groups the board-side raw inputs and the cleaned outputs of the button
//   conditioner into one bundle.
//
// Signals:
//   btn_start_raw     raw start push button (1 = pressed)
//   btn_ld1_raw       raw player-1 load button
//   btn_ld2_raw       raw player-2 load button
//   toggle_switch_raw raw toggle switches [SW_W]
//   button_pulse      one-cycle pulse per accepted start press
//   ld1, ld2          one-cycle pulse per accepted load press
//   start_held        debounced start level
//   ld1_held          debounced ld1 level
//   ld2_held          debounced ld2 level
//   toggle_switch     2-FF synchronized switch value [SW_W]
//
// Modports:
//   master  board / pin side: drives the raw inputs, observes the results
//   slave   the conditioner itself
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int SW_W = 6
);
    logic            btn_start_raw;
    logic            btn_ld1_raw;
    logic            btn_ld2_raw;
    logic [SW_W-1:0] toggle_switch_raw;

    logic            button_pulse;
    logic            ld1;
    logic            ld2;
    logic            start_held;
    logic            ld1_held;
    logic            ld2_held;
    logic [SW_W-1:0] toggle_switch;

    modport master (
        output btn_start_raw, btn_ld1_raw, btn_ld2_raw, toggle_switch_raw,
        input  button_pulse, ld1, ld2, start_held, ld1_held, ld2_held,
               toggle_switch
    );

    modport slave (
        input  btn_start_raw, btn_ld1_raw, btn_ld2_raw, toggle_switch_raw,
        output button_pulse, ld1, ld2, start_held, ld1_held, ld2_held,
               toggle_switch
    );
endinterface

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Front-end conditioner for the Scrambled Number SUM game. Turns the bouncy
//   start / load-1 / load-2 push buttons into synchronized, debounced,
//   single-cycle press pulses plus debounced "held" levels, and passes the
//   toggle switches through a two-flop synchronizer.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronized samples needed to accept
//                    a press or a release (minimum 2)
//   SW_W             toggle-switch bus width
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   button_conditioner_if.slave (raw inputs in, conditioned signals out)
//
// Timing:
//   Raw button high from sampling edge 0 -> pulse high for the one cycle
//   following edge DEBOUNCE_CYCLES+2 (2 synchronizer edges, 1 edge to enter
//   PRESS_WAIT, DEBOUNCE_CYCLES-1 counting edges). Switches: 2-cycle latency,
//   not debounced.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SW_W            = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    button_conditioner_if.slave   bus
);

    localparam int NCH   = 3;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } chan_state_e;

    // Channel order: 0 = start, 1 = ld1, 2 = ld2.
    logic [NCH-1:0] btn_raw;
    logic [NCH-1:0] btn_meta_q;
    logic [NCH-1:0] btn_sync_q;
    logic [NCH-1:0] pulse;
    logic [NCH-1:0] held;

    logic [SW_W-1:0] sw_meta_q;
    logic [SW_W-1:0] sw_sync_q;

    assign btn_raw = {bus.btn_ld2_raw, bus.btn_ld1_raw, bus.btn_start_raw};

    // -------------------------------------------------------------------------
    // Two-flop synchronizers. Only btn_sync_q is ever seen by the channel FSMs.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the two synchronizer stages into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= bus.toggle_switch_raw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel debounce FSM. Channels are identical and independent, so
    // simultaneous presses each produce their own pulse with no arbitration.
    // -------------------------------------------------------------------------
    for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
        chan_state_e      state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             pulse_q;
        logic             held_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                // Pulse is high only in the cycle right after acceptance.
                pulse_q <= 1'b0;

                case (state_q)
                    IDLE: begin
                        if (btn_sync_q[ch]) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end

                    PRESS_WAIT: begin
                        if (!btn_sync_q[ch]) begin
                            // Bounce before the window filled: drop it.
                            state_q <= IDLE;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q <= PRESSED;
                            pulse_q <= 1'b1;
                            held_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    PRESSED: begin
                        if (!btn_sync_q[ch]) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= '0;
                        end
                    end

                    RELEASE_WAIT: begin
                        if (btn_sync_q[ch]) begin
                            // Release bounce: still the same press, no pulse.
                            state_q <= PRESSED;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q <= IDLE;
                            held_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign pulse[ch] = pulse_q;
        assign held[ch]  = held_q;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.button_pulse  = pulse[0];
    assign bus.ld1           = pulse[1];
    assign bus.ld2           = pulse[2];
    assign bus.start_held    = held[0];
    assign bus.ld1_held      = held[1];
    assign bus.ld2_held      = held[2];
    assign bus.toggle_switch = sw_sync_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "edge k" below is the k-th rising edge after a change and
// a registered output set on edge k is visible right after it.
// Expected acceptance edge for a clean press or release: edge 6.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int DB   = 4;
    localparam int SW_W = 6;
    localparam int ACC  = DB + 2;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    button_conditioner_if #(.SW_W(SW_W)) bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .SW_W            (SW_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " pulse"}, bif.button_pulse, 0);
        check({tag, " ld1"},   bif.ld1, 0);
        check({tag, " ld2"},   bif.ld2, 0);
        check({tag, " sh"},    bif.start_held, 0);
        check({tag, " l1h"},   bif.ld1_held, 0);
        check({tag, " l2h"},   bif.ld2_held, 0);
    endtask

    initial begin
        rst                   = 1'b0;
        bif.btn_start_raw     = 1'b0;
        bif.btn_ld1_raw       = 1'b0;
        bif.btn_ld2_raw       = 1'b0;
        bif.toggle_switch_raw = '0;

        // ---------------- reset state ----------------
        #2;
        check_idle_outputs("reset");
        check("reset sw", bif.toggle_switch, 0);
        step();
        step();
        rst = 1'b1;
        step();
        step();

        // ---------------- clean start press ----------------
        bif.btn_start_raw = 1'b1;
        for (int e = 0; e < 20; e++) begin
            step();
            check($sformatf("clean pulse e%0d", e), bif.button_pulse, (e == ACC));
            check($sformatf("clean held e%0d", e), bif.start_held, (e >= ACC));
            check($sformatf("clean ld1 e%0d", e), bif.ld1, 0);
            check($sformatf("clean ld2 e%0d", e), bif.ld2, 0);
        end
        // Release: held drops after a symmetric window, no pulse on release.
        bif.btn_start_raw = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            check($sformatf("rel held e%0d", e), bif.start_held, (e < ACC));
            check($sformatf("rel pulse e%0d", e), bif.button_pulse, 0);
        end

        // ---------------- bounce rejection on ld1 ----------------
        for (int t = 0; t < 4; t++) begin
            bif.btn_ld1_raw = (t % 2 == 0);
            step();
            check($sformatf("bounce ld1 t%0d", t), bif.ld1, 0);
        end
        bif.btn_ld1_raw = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            check($sformatf("bounce pulse e%0d", e), bif.ld1, (e == ACC));
            check($sformatf("bounce held e%0d", e), bif.ld1_held, (e >= ACC));
            check($sformatf("bounce start e%0d", e), bif.button_pulse, 0);
        end
        bif.btn_ld1_raw = 1'b0;
        for (int e = 0; e < 8; e++) step();
        check("bounce released", bif.ld1_held, 0);

        // ---------------- release bounce on start ----------------
        bif.btn_start_raw = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            check($sformatf("rb press e%0d", e), bif.button_pulse, (e == ACC));
        end
        bif.btn_start_raw = 1'b0;
        step();
        step();
        bif.btn_start_raw = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            check($sformatf("rb held e%0d", e), bif.start_held, 1);
            check($sformatf("rb nopulse e%0d", e), bif.button_pulse, 0);
        end
        bif.btn_start_raw = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            check($sformatf("rb rel held e%0d", e), bif.start_held, (e < ACC));
        end
        bif.btn_start_raw = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            check($sformatf("rb second e%0d", e), bif.button_pulse, (e == ACC));
        end
        bif.btn_start_raw = 1'b0;
        for (int e = 0; e < 10; e++) step();
        check("rb idle", bif.start_held, 0);

        // ---------------- simultaneous ld1 / ld2 ----------------
        bif.btn_ld1_raw = 1'b1;
        bif.btn_ld2_raw = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            check($sformatf("sim ld1 e%0d", e), bif.ld1, (e == ACC));
            check($sformatf("sim ld2 e%0d", e), bif.ld2, (e == ACC));
            check($sformatf("sim start e%0d", e), bif.button_pulse, 0);
        end
        bif.btn_ld1_raw = 1'b0;
        bif.btn_ld2_raw = 1'b0;
        for (int e = 0; e < 10; e++) step();
        check("sim l1 idle", bif.ld1_held, 0);
        check("sim l2 idle", bif.ld2_held, 0);

        // ---------------- switches ----------------
        bif.toggle_switch_raw = 6'b110101;
        step();
        check("sw edge0", bif.toggle_switch, 6'b000000);
        step();
        check("sw edge1", bif.toggle_switch, 6'b110101);

        // ---------------- async reset during PRESS_WAIT ----------------
        bif.btn_start_raw = 1'b1;
        step();
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        check_idle_outputs("arst");
        check("arst sw", bif.toggle_switch, 6'b000000);
        step();
        step();
        check_idle_outputs("arst hold");
        rst = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            check($sformatf("arst pulse e%0d", e), bif.button_pulse, (e == ACC));
            check($sformatf("arst held e%0d", e), bif.start_held, (e >= ACC));
        end
        check("arst sw back", bif.toggle_switch, 6'b110101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
